e203_exu_wbck_buf: RTL and testbench

Write-back buffer and arbiter sitting directly downstream of the regular ALU in the EXU. Accepts ALU write-back results through a valid/ready handshake into a small FIFO and merges them with long-pipe write-backs (LSU/MulDiv) onto the single register-file write port. Long-pipe has priority; an anti-starvation counter guarantees forward progress for buffered ALU results. The register-file port is registered.

---
 rtl/e203_exu_pkg.sv | 19 +
 rtl/e203_exu_wbck_fifo.sv | 64 ++++++
 rtl/e203_exu_wbck_buf.sv | 108 ++++++++++
 tb/tb_e203_exu_wbck_buf.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_pkg.sv
// Shared EXU write-back types: default widths, the buffered entry layout and
// the per-cycle register-file port grant encoding.
package e203_exu_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RFIDX_W_DEF = 5;

    typedef struct packed {
        logic [XLEN_DEF-1:0]    wdat;
        logic [RFIDX_W_DEF-1:0] rdidx;
    } wbck_ent_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_LONGP = 2'd1,
        GNT_ALU   = 2'd2
    } gnt_e;

endpackage

// File: rtl/e203_exu_wbck_fifo.sv
// Small synchronous FIFO with occupancy count; head data is visible whenever
// the FIFO is non-empty. Overflowing pushes and underflowing pops are ignored.
module e203_exu_wbck_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign cnt_o      = cnt_q;

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/e203_exu_wbck_buf.sv
// ALU write-back buffer merged with long-pipe write-backs onto one registered
// register-file port; long-pipe wins unless the buffered ALU head has starved.
module e203_exu_wbck_buf
    import e203_exu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RFIDX_W    = RFIDX_W_DEF,
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_wbck_i_valid,
    output logic                       alu_wbck_i_ready,
    input  logic [XLEN-1:0]            alu_wbck_i_wdat,
    input  logic [RFIDX_W-1:0]         alu_wbck_i_rdidx,
    input  logic                       longp_wbck_i_valid,
    output logic                       longp_wbck_i_ready,
    input  logic [XLEN-1:0]            longp_wbck_i_wdat,
    input  logic [RFIDX_W-1:0]         longp_wbck_i_rdidx,
    output logic                       rf_wbck_o_ena,
    output logic [XLEN-1:0]            rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0]         rf_wbck_o_rdidx,
    output logic [$clog2(DEPTH+1)-1:0] buf_cnt,
    output logic                       wbck_busy
);

    localparam int EW = XLEN + RFIDX_W;
    localparam int SW = $clog2(STARVE_LIM+1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    logic [EW-1:0]      head_ent;
    logic               fifo_full, fifo_empty, head_vld, frc_gnt;
    gnt_e               gnt;
    logic [SW-1:0]      starve_q, starve_d;
    logic               ena_q, ena_d;
    logic [XLEN-1:0]    wdat_q, wdat_d;
    logic [RFIDX_W-1:0] rdidx_q, rdidx_d;

    e203_exu_wbck_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (alu_wbck_i_valid),
        .push_dat_i ({alu_wbck_i_wdat, alu_wbck_i_rdidx}),
        .pop_i      (gnt == GNT_ALU),
        .head_dat_o (head_ent),
        .cnt_o      (buf_cnt),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign head_vld           = !fifo_empty;
    assign frc_gnt            = head_vld && (starve_q == STARVE_MAX);
    assign alu_wbck_i_ready   = !fifo_full;
    assign longp_wbck_i_ready = !frc_gnt;

    always_comb begin
        gnt      = GNT_NONE;
        starve_d = starve_q;
        ena_d    = 1'b0;
        wdat_d   = wdat_q;
        rdidx_d  = rdidx_q;
        if (frc_gnt)                 gnt = GNT_ALU;
        else if (longp_wbck_i_valid) gnt = GNT_LONGP;
        else if (head_vld)           gnt = GNT_ALU;

        // A head that is not granted can only have lost to the long pipe.
        if (!head_vld || gnt == GNT_ALU) starve_d = '0;
        else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);

        case (gnt)
            GNT_ALU: begin
                wdat_d  = head_ent[EW-1:RFIDX_W];
                rdidx_d = head_ent[RFIDX_W-1:0];
                ena_d   = (head_ent[RFIDX_W-1:0] != '0);
            end
            GNT_LONGP: begin
                wdat_d  = longp_wbck_i_wdat;
                rdidx_d = longp_wbck_i_rdidx;
                ena_d   = (longp_wbck_i_rdidx != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            ena_q    <= 1'b0;
            wdat_q   <= '0;
            rdidx_q  <= '0;
        end else begin
            starve_q <= starve_d;
            ena_q    <= ena_d;
            wdat_q   <= wdat_d;
            rdidx_q  <= rdidx_d;
        end
    end

    assign rf_wbck_o_ena   = ena_q;
    assign rf_wbck_o_wdat  = wdat_q;
    assign rf_wbck_o_rdidx = rdidx_q;
    assign wbck_busy       = (buf_cnt != '0) || ena_q;

endmodule

// File: tb/tb_e203_exu_wbck_buf.sv
// Bench for the write-back buffer: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_e203_exu_wbck_buf;
    import e203_exu_pkg::*;

    localparam int XLEN       = 32;
    localparam int RFIDX_W    = 5;
    localparam int DEPTH      = 2;
    localparam int STARVE_LIM = 4;
    localparam int CW         = $clog2(DEPTH+1);

    logic               clk = 1'b0;
    logic               rst;
    logic               alu_v, alu_ready;
    logic [XLEN-1:0]    alu_wdat;
    logic [RFIDX_W-1:0] alu_rdidx;
    logic               longp_v, longp_ready;
    logic [XLEN-1:0]    longp_wdat;
    logic [RFIDX_W-1:0] longp_rdidx;
    logic               rf_ena;
    logic [XLEN-1:0]    rf_wdat;
    logic [RFIDX_W-1:0] rf_rdidx;
    logic [CW-1:0]      buf_cnt;
    logic               wbck_busy;

    e203_exu_wbck_buf #(
        .XLEN (XLEN), .RFIDX_W (RFIDX_W), .DEPTH (DEPTH), .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_wbck_i_valid   (alu_v),
        .alu_wbck_i_ready   (alu_ready),
        .alu_wbck_i_wdat    (alu_wdat),
        .alu_wbck_i_rdidx   (alu_rdidx),
        .longp_wbck_i_valid (longp_v),
        .longp_wbck_i_ready (longp_ready),
        .longp_wbck_i_wdat  (longp_wdat),
        .longp_wbck_i_rdidx (longp_rdidx),
        .rf_wbck_o_ena      (rf_ena),
        .rf_wbck_o_wdat     (rf_wdat),
        .rf_wbck_o_rdidx    (rf_rdidx),
        .buf_cnt            (buf_cnt),
        .wbck_busy          (wbck_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending ALU results are a plain queue, starvation is a
    // count of cycles the oldest one has been passed over.
    wbck_ent_t          exp_q[$];
    int                 m_starve;
    logic               m_ena;
    logic [XLEN-1:0]    m_wdat;
    logic [RFIDX_W-1:0] m_rdidx;

    always @(posedge clk) begin : model
        bit head, frc, can_push;
        wbck_ent_t e;
        if (rst) begin
            exp_q.delete();
            m_starve = 0;
            m_ena    = 1'b0;
            m_wdat   = '0;
            m_rdidx  = '0;
        end else begin
            can_push = exp_q.size() < DEPTH;
            head     = exp_q.size() > 0;
            frc      = head && (m_starve == STARVE_LIM);
            if (frc || (head && !longp_v)) begin
                e        = exp_q.pop_front();
                m_wdat   = e.wdat;
                m_rdidx  = e.rdidx;
                m_ena    = (e.rdidx != 0);
                m_starve = 0;
            end else if (longp_v) begin
                m_wdat   = longp_wdat;
                m_rdidx  = longp_rdidx;
                m_ena    = (longp_rdidx != 0);
                m_starve = head ? m_starve + 1 : 0;
            end else begin
                m_ena    = 1'b0;
                m_starve = 0;
            end
            if (alu_v && can_push) exp_q.push_back('{wdat: alu_wdat, rdidx: alu_rdidx});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_alu_ready", 32'(alu_ready), 32'(exp_q.size() < DEPTH));
            chk("m_longp_ready", 32'(longp_ready),
                32'(!(exp_q.size() > 0 && m_starve == STARVE_LIM)));
            chk("m_buf_cnt", 32'(buf_cnt), 32'(exp_q.size()));
            chk("m_rf_ena", 32'(rf_ena), 32'(m_ena));
            chk("m_rf_wdat", rf_wdat, m_wdat);
            chk("m_rf_rdidx", 32'(rf_rdidx), 32'(m_rdidx));
            chk("m_busy", 32'(wbck_busy), 32'(exp_q.size() != 0 || m_ena));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [31:0] d, input logic [4:0] r);
        alu_v = v; alu_wdat = d; alu_rdidx = r;
    endtask

    task automatic drive_longp(input logic v, input logic [31:0] d, input logic [4:0] r);
        longp_v = v; longp_wdat = d; longp_rdidx = r;
    endtask

    initial begin
        int n;
        // Reset with both sources asserting valid.
        rst = 1'b1;
        drive_alu(1'b1, 32'hAAAA_0001, 5'd9);
        drive_longp(1'b1, 32'hBBBB_0002, 5'd10);
        tick();
        chk_en = 1;
        tick();
        chk("rst_ena", 32'(rf_ena), 32'd0);
        chk("rst_cnt", 32'(buf_cnt), 32'd0);
        chk("rst_wdat", rf_wdat, 32'd0);
        rst = 1'b0;
        drive_alu(1'b0, 32'd0, 5'd0);
        drive_longp(1'b0, 32'd0, 5'd0);
        #1;
        chk("rst_ready", 32'(alu_ready), 32'd1);
        chk("rst_busy", 32'(wbck_busy), 32'd0);

        // ALU only: two-cycle latency to the register file.
        drive_alu(1'b1, 32'hDEAD_BEEF, 5'd5);
        tick();
        drive_alu(1'b0, 32'd0, 5'd0);
        chk("alu_cnt1", 32'(buf_cnt), 32'd1);
        chk("alu_ena_early", 32'(rf_ena), 32'd0);
        tick();
        chk("alu_ena", 32'(rf_ena), 32'd1);
        chk("alu_wdat", rf_wdat, 32'hDEAD_BEEF);
        chk("alu_rdidx", 32'(rf_rdidx), 32'd5);
        chk("alu_cnt0", 32'(buf_cnt), 32'd0);
        tick();
        chk("alu_ena_off", 32'(rf_ena), 32'd0);

        // Starvation: head loses exactly 4 cycles, then is forced through once.
        drive_longp(1'b1, 32'h1000, 5'd7);
        drive_alu(1'b1, 32'h11, 5'd3);
        tick();
        drive_alu(1'b0, 32'd0, 5'd0);
        n = 0;
        while (longp_ready === 1'b1 && n < 10) begin
            n++;
            drive_longp(1'b1, 32'h1000 + 32'(n), 5'd7);
            tick();
        end
        chk("starve_lost", 32'(n), 32'd4);
        chk("starve_drop", 32'(longp_ready), 32'd0);
        tick();
        chk("starve_wdat", rf_wdat, 32'h11);
        chk("starve_rdidx", 32'(rf_rdidx), 32'd3);
        chk("starve_ena", 32'(rf_ena), 32'd1);
        chk("starve_once", 32'(longp_ready), 32'd1);
        drive_longp(1'b0, 32'd0, 5'd0);
        tick();

        // Full FIFO under continuous long-pipe traffic.
        drive_longp(1'b1, 32'h2000, 5'd7);
        drive_alu(1'b1, 32'hA1, 5'd1);
        tick();
        drive_alu(1'b1, 32'hB2, 5'd2);
        drive_longp(1'b1, 32'h2001, 5'd7);
        tick();
        drive_alu(1'b1, 32'hC3, 5'd3);
        drive_longp(1'b1, 32'h2002, 5'd7);
        chk("full_ready", 32'(alu_ready), 32'd0);
        chk("full_cnt", 32'(buf_cnt), 32'd2);
        tick();
        drive_alu(1'b0, 32'd0, 5'd0);
        n = 0;
        while (!(rf_ena === 1'b1 && rf_rdidx === 5'd1) && n < 20) begin
            n++;
            drive_longp(1'b1, 32'h2100 + 32'(n), 5'd7);
            tick();
        end
        chk("full_a_wait", 32'(n), 32'd3);
        chk("full_a_wdat", rf_wdat, 32'hA1);
        n = 0;
        while (!(rf_ena === 1'b1 && rf_rdidx === 5'd2) && n < 20) begin
            n++;
            drive_longp(1'b1, 32'h2200 + 32'(n), 5'd7);
            tick();
        end
        chk("full_b_wait", 32'(n), 32'd5);
        chk("full_b_wdat", rf_wdat, 32'hB2);
        chk("full_drain", 32'(buf_cnt), 32'd0);
        drive_longp(1'b0, 32'd0, 5'd0);
        tick();

        // Write to x0 is consumed silently; the next long-pipe write is normal.
        drive_alu(1'b1, 32'h1234, 5'd0);
        tick();
        drive_alu(1'b0, 32'd0, 5'd0);
        tick();
        chk("x0_ena", 32'(rf_ena), 32'd0);
        chk("x0_wdat", rf_wdat, 32'h1234);
        chk("x0_cnt", 32'(buf_cnt), 32'd0);
        drive_longp(1'b1, 32'h55, 5'd7);
        chk("x0_lp_ready", 32'(longp_ready), 32'd1);
        tick();
        drive_longp(1'b0, 32'd0, 5'd0);
        chk("lp_ena", 32'(rf_ena), 32'd1);
        chk("lp_wdat", rf_wdat, 32'h55);
        chk("lp_rdidx", 32'(rf_rdidx), 32'd7);

        // Reset mid-operation drops buffered entries.
        drive_longp(1'b1, 32'h3000, 5'd8);
        drive_alu(1'b1, 32'hE1, 5'd11);
        tick();
        drive_alu(1'b1, 32'hE2, 5'd12);
        tick();
        chk("mid_cnt2", 32'(buf_cnt), 32'd2);
        rst = 1'b1;
        drive_alu(1'b0, 32'd0, 5'd0);
        drive_longp(1'b0, 32'd0, 5'd0);
        tick();
        rst = 1'b0;
        chk("mid_cnt0", 32'(buf_cnt), 32'd0);
        chk("mid_wdat", rf_wdat, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_write", 32'(rf_ena), 32'd0);
        end

        // Mixed deterministic traffic, checked by the model every cycle.
        for (int i = 0; i < 48; i++) begin
            drive_alu(i % 3 != 2, 32'h4000 + 32'(i), 5'(i % 8));
            drive_longp(i % 5 < 3, 32'h5000 + 32'(i), 5'((i * 3) % 32));
            tick();
        end
        drive_alu(1'b0, 32'd0, 5'd0);
        drive_longp(1'b0, 32'd0, 5'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("end_idle", 32'(wbck_busy), 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
